dram_clk_sequencer: RTL and testbench



---
 rtl/dram_clk_sequencer_if.sv | 36 +++
 rtl/dram_clk_sequencer.sv | 164 ++++++++++++++++
 tb/tb_dram_clk_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dram_clk_sequencer_if.sv
// ============================================================================
// Module  : dram_clk_sequencer_if
// Purpose : Lock inputs, restart request and status outputs of the DRAM
//           clock-chain sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface dram_clk_sequencer_if;
  logic       clk_in_locked;
  logic       dcm_locked;
  logic       pll_locked;
  logic       restart;
  logic       dcm_rst;
  logic       pll_rst;
  logic       dram_rst_req;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  modport master (
    input  clk_in_locked, dcm_locked, pll_locked, restart,
    output dcm_rst, pll_rst, dram_rst_req, ready, fault,
           state, retry_count, lock_loss_count
  );

  modport slave (
    output clk_in_locked, dcm_locked, pll_locked, restart,
    input  dcm_rst, pll_rst, dram_rst_req, ready, fault,
           state, retry_count, lock_loss_count
  );
endinterface

`default_nettype wire

// File: rtl/dram_clk_sequencer.sv
// ============================================================================
// Module  : dram_clk_sequencer
// Purpose : Brings up the DCM -> PLL chain with lock timeouts, bounded retries
//           and a settle interval; holds the DRAM controller in reset meanwhile.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dram_clk_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 20
) (
  input  wire logic              clk,
  input  wire logic              reset,
  dram_clk_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    RST_DCM  = 3'd0,
    WAIT_DCM = 3'd1,
    RST_PLL  = 3'd2,
    WAIT_PLL = 3'd3,
    SETTLE   = 3'd4,
    READY    = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_lock_last   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       c_max_retry   = 4'(MAX_RETRIES);
  localparam logic [3:0]       c_last_retry  = 4'(MAX_RETRIES - 1);

  logic [1:0]       r_ci_sync, r_dcm_sync, r_pll_sync;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic [3:0]       r_retry, w_retry_nxt;
  logic [7:0]       r_llc, w_llc_nxt, w_llc_inc;
  logic             r_dcm_rst, r_pll_rst, r_dram_rst_req, r_ready, r_fault;
  logic             w_ci_s, w_dcm_s, w_pll_s;
  logic             w_do_retry, w_hold, w_clear;

  assign w_ci_s    = r_ci_sync[1];
  assign w_dcm_s   = r_dcm_sync[1];
  assign w_pll_s   = r_pll_sync[1];
  assign w_llc_inc = (r_llc == 8'hFF) ? r_llc : r_llc + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_llc_nxt   = r_llc;
    w_do_retry  = 1'b0;
    w_hold      = 1'b0;
    w_clear     = 1'b0;

    if (bus.restart) begin
      // A restart always begins a fresh reset pulse, even from RST_DCM.
      w_state_nxt = RST_DCM;
      w_retry_nxt = 4'd0;
      w_clear     = 1'b1;
    end else if (!w_ci_s && r_state != RST_DCM && r_state != FAULT) begin
      w_state_nxt = RST_DCM;
      if (r_state == READY) w_llc_nxt = w_llc_inc;
    end else begin
      case (r_state)
        RST_DCM: begin
          if (r_timer == c_rst_last) begin
            if (w_ci_s) w_state_nxt = WAIT_DCM;
            else        w_hold      = 1'b1;
          end
        end
        WAIT_DCM: begin
          if (w_dcm_s)                     w_state_nxt = RST_PLL;
          else if (r_timer == c_lock_last) w_do_retry  = 1'b1;
        end
        RST_PLL: begin
          if (!w_dcm_s)                   w_do_retry  = 1'b1;
          else if (r_timer == c_rst_last) w_state_nxt = WAIT_PLL;
        end
        WAIT_PLL: begin
          if (w_dcm_s && w_pll_s)                        w_state_nxt = SETTLE;
          else if (!w_dcm_s || r_timer == c_lock_last)   w_do_retry  = 1'b1;
        end
        SETTLE: begin
          if (!w_dcm_s || !w_pll_s) begin
            w_do_retry = 1'b1;
          end else if (r_timer == c_settle_last) begin
            w_state_nxt = READY;
            w_retry_nxt = 4'd0;
          end
        end
        READY: begin
          if (!w_dcm_s || !w_pll_s) begin
            w_state_nxt = RST_DCM;
            w_llc_nxt   = w_llc_inc;
            w_retry_nxt = 4'd0;
          end
        end
        FAULT:   w_state_nxt = FAULT;
        default: w_state_nxt = RST_DCM;
      endcase
    end

    if (w_do_retry) begin
      if (r_retry == c_last_retry) begin
        w_state_nxt = FAULT;
        w_retry_nxt = c_max_retry;
      end else begin
        w_state_nxt = RST_DCM;
        w_retry_nxt = r_retry + 4'd1;
      end
    end

    if (w_state_nxt != r_state || w_clear) w_timer_nxt = '0;
    else if (w_hold)                       w_timer_nxt = r_timer;
    else                                   w_timer_nxt = r_timer + 1'b1;
  end

  // Outputs decode from the next state so they change on the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ci_sync      <= 2'b00;
      r_dcm_sync     <= 2'b00;
      r_pll_sync     <= 2'b00;
      r_state        <= RST_DCM;
      r_timer        <= '0;
      r_retry        <= 4'd0;
      r_llc          <= 8'd0;
      r_dcm_rst      <= 1'b1;
      r_pll_rst      <= 1'b1;
      r_dram_rst_req <= 1'b1;
      r_ready        <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_ci_sync      <= {r_ci_sync[0],  bus.clk_in_locked};
      r_dcm_sync     <= {r_dcm_sync[0], bus.dcm_locked};
      r_pll_sync     <= {r_pll_sync[0], bus.pll_locked};
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_retry        <= w_retry_nxt;
      r_llc          <= w_llc_nxt;
      r_dcm_rst      <= (w_state_nxt == RST_DCM) || (w_state_nxt == FAULT);
      r_pll_rst      <= w_state_nxt inside {RST_DCM, WAIT_DCM, RST_PLL, FAULT};
      r_dram_rst_req <= (w_state_nxt != READY);
      r_ready        <= (w_state_nxt == READY);
      r_fault        <= (w_state_nxt == FAULT);
    end
  end

  assign bus.dcm_rst         = r_dcm_rst;
  assign bus.pll_rst         = r_pll_rst;
  assign bus.dram_rst_req    = r_dram_rst_req;
  assign bus.ready           = r_ready;
  assign bus.fault           = r_fault;
  assign bus.state           = r_state;
  assign bus.retry_count     = r_retry;
  assign bus.lock_loss_count = r_llc;

endmodule

`default_nettype wire

// File: tb/tb_dram_clk_sequencer.sv
// ============================================================================
// Module  : tb_dram_clk_sequencer
// Purpose : Directed vector bench for the DRAM clock-chain sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_dram_clk_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dram_clk_sequencer_if bus();

  dram_clk_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .SETTLE_CYCLES(8),
    .MAX_RETRIES  (3),
    .CNT_W        (20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         rep;
    logic       ci, d, p;
    logic [2:0] st;
    logic       dr, pr, rdy;
  } vec_t;

  vec_t       tbl[13];
  int         vectors = 0;
  int         fails   = 0;
  logic [7:0] exp_llc;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic ci, input logic d, input logic p);
    bus.clk_in_locked = ci;
    bus.dcm_locked    = d;
    bus.pll_locked    = p;
  endtask

  task automatic check(input string nm, input logic [2:0] st, input logic dr, input logic pr,
                       input logic rdy, input logic flt, input logic [3:0] rc, input logic [7:0] llc);
    vectors++;
    if (bus.state !== st || bus.dcm_rst !== dr || bus.pll_rst !== pr || bus.ready !== rdy ||
        bus.dram_rst_req !== ~rdy || bus.fault !== flt || bus.retry_count !== rc ||
        bus.lock_loss_count !== llc) begin
      fails++;
      $display("FAIL %s: got st=%0d dcm_rst=%b pll_rst=%b ready=%b dram_rst_req=%b fault=%b retry=%0d llc=%0d; want st=%0d dcm_rst=%b pll_rst=%b ready=%b dram_rst_req=%b fault=%b retry=%0d llc=%0d",
               nm, bus.state, bus.dcm_rst, bus.pll_rst, bus.ready, bus.dram_rst_req, bus.fault,
               bus.retry_count, bus.lock_loss_count, st, dr, pr, rdy, ~rdy, flt, rc, llc);
    end
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s, input int budget);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (bus.state !== s) begin
      fails++;
      $display("FAIL %s: state=%0d after %0d cycles, want %0d", nm, bus.state, n, s);
    end
  endtask

  // Reset is released #1 after an edge, so the next posedge is cycle 1.
  task automatic do_reset(input logic ci, input logic d, input logic p);
    set_in(ci, d, p);
    bus.restart = 1'b0;
    reset = 1'b1;
    step(2);
    check("reset_values", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    bus.restart = 1'b0;

    //          rep ci    d     p     st    dcm   pll   rdy
    tbl[0]  = '{3,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,  1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{10, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{2,  1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1,  1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{3,  1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1,  1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{10, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2,  1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1,  1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{7,  1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1,  1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{5,  1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1};

    // Clean bring-up, locks arriving 10 cycles after each reset release.
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].ci, tbl[i].d, tbl[i].p);
      step(tbl[i].rep);
      check($sformatf("bringup_row%0d", i), tbl[i].st, tbl[i].dr, tbl[i].pr, tbl[i].rdy,
            1'b0, 4'd0, 8'd0);
    end

    // One-cycle PLL dropout while READY.
    set_in(1'b1, 1'b1, 1'b0);
    step();
    check("drop_c1", 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
    set_in(1'b1, 1'b1, 1'b1);
    step();
    check("drop_c2", 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
    step();
    check("drop_c3", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);

    for (int i = 2; i <= 256; i++) begin
      wait_state("relock", 3'd5, 40);
      set_in(1'b1, 1'b1, 1'b0);
      step();
      set_in(1'b1, 1'b1, 1'b1);
      step(2);
      exp_llc = (i > 255) ? 8'd255 : 8'(i);
      if (i == 2 || i == 255 || i == 256)
        check($sformatf("lock_loss_%0d", i), 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, exp_llc);
    end

    // DCM never locks: three timeouts then FAULT.
    do_reset(1'b1, 1'b0, 1'b0);
    step(23);
    check("to1_pre",  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    step();
    check("to1",      3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);
    step(23);
    check("to2_pre",  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);
    step();
    check("to2",      3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 8'd0);
    step(23);
    check("to3_pre",  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 8'd0);
    step();
    check("fault",    3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 8'd0);
    step(2);
    check("fault_hold", 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 8'd0);
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    check("restart", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    // Restart on the same cycle as the final timeout beats FAULT.
    step(71);
    check("race_pre", 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 8'd0);
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    check("race_restart", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);

    // DCM glitch during SETTLE.
    do_reset(1'b1, 1'b1, 1'b1);
    wait_state("to_settle", 3'd4, 30);
    step(2);
    set_in(1'b1, 1'b0, 1'b1);
    step();
    set_in(1'b1, 1'b1, 1'b1);
    step();
    check("glitch_pre", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    step();
    check("glitch",     3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);

    // Reference lock lost in WAIT_PLL: no retry charged, hold until it returns.
    set_in(1'b1, 1'b1, 1'b0);
    wait_state("to_wait_pll", 3'd3, 20);
    set_in(1'b0, 1'b1, 1'b0);
    step(2);
    check("ci_loss_pre", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 8'd0);
    step();
    check("ci_loss",     3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);
    step(10);
    check("ci_hold",     3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);
    set_in(1'b1, 1'b1, 1'b0);
    step(2);
    check("ci_back_pre", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);
    step();
    check("ci_back",     3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 8'd0);

    // Asynchronous reset between edges while READY.
    do_reset(1'b1, 1'b1, 1'b1);
    wait_state("to_ready", 3'd5, 40);
    check("ready_pre", 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    step();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
